// File: rtl/piso_serializer_gen.sv
// Parallel-in/serial-out serializer with a one-word holding buffer ahead of the shifter.
// Optional PISO_IDLE_INSERT_EN: shift IDLE_WORD continuously whenever no data word is in flight.
module piso_serializer_gen #(
   parameter int unsigned      WIDTH     = 10,
   parameter bit               LSB_FIRST = 1'b1,
   parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b0011111010),
   parameter int unsigned      CNT_W     = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] parallel_in,
   output logic             serial_out,
   output logic             serial_valid,
   output logic [CNT_W-1:0] bit_count,
   output logic             word_start,
   output logic             underrun
);

   localparam logic [0:0]       ST_IDLE  = 1'b0;
   localparam logic [0:0]       ST_SHIFT = 1'b1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   logic [0:0]       state, state_n;
   logic [WIDTH-1:0] shift_reg, shift_n;
   logic [WIDTH-1:0] hold_data, hold_data_n;
   logic             hold_full, hold_full_n;
   logic [CNT_W-1:0] cnt_n;
   logic             sout_n, sval_n, ws_n, ur_n, in_ready_n;
   logic             load_en, load_is_data, step_en, take;
   logic [WIDTH-1:0] load_data;

   // Bit presented first for a freshly loaded word
   function automatic logic first_bit(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? w[0] : w[WIDTH-1];
   endfunction

   // Drop the bit just presented so the next one sits at the output end
   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return LSB_FIRST ? (w >> 1) : (w << 1);
   endfunction

`ifndef PISO_IDLE_INSERT_EN
   logic unused_idle_word;
   assign unused_idle_word = ^IDLE_WORD;
`endif

   always_comb begin
      state_n      = state;
      shift_n      = shift_reg;
      cnt_n        = bit_count;
      sout_n       = serial_out;
      sval_n       = serial_valid;
      ws_n         = 1'b0;
      ur_n         = 1'b0;
      load_en      = 1'b0;
      load_is_data = 1'b0;
      load_data    = hold_data;
      step_en      = 1'b0;
      take         = 1'b0;

      case (state)
         ST_IDLE: begin
`ifdef PISO_IDLE_INSERT_EN
            // Idle words are atomic; !serial_valid marks the very first boundary after reset
            if (!serial_valid || bit_count == LAST_CNT) begin
               load_en = 1'b1;
               if (hold_full) begin
                  load_is_data = 1'b1;
                  take         = 1'b1;
                  state_n      = ST_SHIFT;
               end else begin
                  load_data = IDLE_WORD;
               end
            end else begin
               step_en = 1'b1;
            end
`else
            if (hold_full) begin
               load_en      = 1'b1;
               load_is_data = 1'b1;
               take         = 1'b1;
               state_n      = ST_SHIFT;
            end else begin
               sout_n = 1'b0;
               sval_n = 1'b0;
               cnt_n  = '0;
            end
`endif
         end
         ST_SHIFT: begin
            if (bit_count == LAST_CNT) begin
               if (hold_full) begin
                  load_en      = 1'b1;
                  load_is_data = 1'b1;
                  take         = 1'b1;
               end else begin
                  state_n = ST_IDLE;
                  ur_n    = 1'b1;
`ifdef PISO_IDLE_INSERT_EN
                  load_en   = 1'b1;
                  load_data = IDLE_WORD;
`else
                  sout_n = 1'b0;
                  sval_n = 1'b0;
                  cnt_n  = '0;
`endif
               end
            end else begin
               step_en = 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase

      if (load_en) begin
         sout_n  = first_bit(load_data);
         shift_n = advance(load_data);
         cnt_n   = '0;
         sval_n  = 1'b1;
         ws_n    = load_is_data;
      end
      if (step_en) begin
         sout_n  = first_bit(shift_reg);
         shift_n = advance(shift_reg);
         cnt_n   = bit_count + CNT_W'(1);
      end

      // Holding buffer: transfer and accept never coincide since in_ready mirrors !hold_full
      hold_full_n = hold_full & ~take;
      hold_data_n = hold_data;
      if (in_valid && in_ready) begin
         hold_full_n = 1'b1;
         hold_data_n = parallel_in;
      end
      in_ready_n = ~hold_full_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         shift_reg    <= '0;
         hold_data    <= '0;
         hold_full    <= 1'b0;
         bit_count    <= '0;
         serial_out   <= 1'b0;
         serial_valid <= 1'b0;
         word_start   <= 1'b0;
         underrun     <= 1'b0;
         in_ready     <= 1'b0;
      end else begin
         state        <= state_n;
         shift_reg    <= shift_n;
         hold_data    <= hold_data_n;
         hold_full    <= hold_full_n;
         bit_count    <= cnt_n;
         serial_out   <= sout_n;
         serial_valid <= sval_n;
         word_start   <= ws_n;
         underrun     <= ur_n;
         in_ready     <= in_ready_n;
      end
   end

endmodule

// File: tb/tb_piso_serializer_gen.sv
// Directed bench for piso_serializer_gen: LSB-first and MSB-first instances, streaming, reset abort.
// Idle-fill scenario is compiled when PISO_IDLE_INSERT_EN is defined.
module tb_piso_serializer_gen;

   logic       clk;
   logic       rst;
   logic       in_valid, in_ready;
   logic [9:0] parallel_in;
   logic       serial_out, serial_valid, word_start, underrun;
   logic [3:0] bit_count;

   logic       m_valid, m_ready;
   logic [9:0] m_data;
   logic       m_sout, m_sval, m_ws, m_ur;
   logic [3:0] m_cnt;

   int checks   = 0;
   int failures = 0;
   logic [9:0] prod_q[$];

   piso_serializer_gen #(.WIDTH(10), .LSB_FIRST(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .parallel_in(parallel_in), .serial_out(serial_out), .serial_valid(serial_valid),
      .bit_count(bit_count), .word_start(word_start), .underrun(underrun)
   );

   piso_serializer_gen #(.WIDTH(10), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .in_valid(m_valid), .in_ready(m_ready),
      .parallel_in(m_data), .serial_out(m_sout), .serial_valid(m_sval),
      .bit_count(m_cnt), .word_start(m_ws), .underrun(m_ur)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; a word handed over on this edge is replaced by the next queued word or in_valid drops
   task automatic tick();
      logic acc;
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
         if (prod_q.size() > 0) parallel_in = prod_q.pop_front();
         else in_valid = 1'b0;
      end
   endtask

   initial begin
      logic [9:0] wd;
      logic [9:0] words [3];
      logic [9:0] idle_w;

      rst = 1'b1; in_valid = 1'b0; parallel_in = '0; m_valid = 1'b0; m_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_serial_out", 32'(serial_out), 32'(0));
      chk("rst_serial_valid", 32'(serial_valid), 32'(0));
      chk("rst_bit_count", 32'(bit_count), 32'(0));
      chk("rst_word_start", 32'(word_start), 32'(0));
      chk("rst_underrun", 32'(underrun), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'(1));

`ifdef PISO_IDLE_INSERT_EN
      idle_w = 10'b0011111010;
      for (int i = 0; i < 10; i++) begin
         if (i > 0) tick();
         chk("idle_bit", 32'(serial_out), 32'(idle_w[i]));
         chk("idle_valid", 32'(serial_valid), 32'(1));
         chk("idle_cnt", 32'(bit_count), 32'(i));
         chk("idle_ws", 32'(word_start), 32'(0));
         if (i == 3) begin
            parallel_in = 10'h2A5;
            in_valid    = 1'b1;
         end
      end
      wd = 10'h2A5;
      for (int j = 0; j < 10; j++) begin
         tick();
         chk("idle_data_bit", 32'(serial_out), 32'(wd[j]));
         chk("idle_data_cnt", 32'(bit_count), 32'(j));
         chk("idle_data_ws", 32'(word_start), 32'(j == 0));
      end
      tick();
      chk("idle_ur", 32'(underrun), 32'(1));
      chk("idle_resume_valid", 32'(serial_valid), 32'(1));
      chk("idle_resume_bit", 32'(serial_out), 32'(idle_w[0]));
      chk("idle_resume_cnt", 32'(bit_count), 32'(0));
      chk("idle_resume_ws", 32'(word_start), 32'(0));
`else
      // Single word, LSB first
      wd = 10'h2A5;
      parallel_in = wd; in_valid = 1'b1;
      tick();
      chk("t1_ready_low", 32'(in_ready), 32'(0));
      chk("t1_not_yet_valid", 32'(serial_valid), 32'(0));
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t1_bit", 32'(serial_out), 32'(wd[i]));
         chk("t1_valid", 32'(serial_valid), 32'(1));
         chk("t1_cnt", 32'(bit_count), 32'(i));
         chk("t1_ws", 32'(word_start), 32'(i == 0));
         chk("t1_no_ur", 32'(underrun), 32'(0));
      end
      tick();
      chk("t1_ur", 32'(underrun), 32'(1));
      chk("t1_idle_valid", 32'(serial_valid), 32'(0));
      chk("t1_idle_out", 32'(serial_out), 32'(0));
      chk("t1_ready_back", 32'(in_ready), 32'(1));
      tick();
      chk("t1_ur_pulse", 32'(underrun), 32'(0));

      // Three words back to back; in_ready also checked against hold occupancy
      words[0] = 10'h3FF; words[1] = 10'h000; words[2] = 10'h155;
      prod_q.push_back(words[1]);
      prod_q.push_back(words[2]);
      parallel_in = words[0]; in_valid = 1'b1;
      tick();
      for (int j = 0; j < 30; j++) begin
         tick();
         wd = words[j / 10];
         chk("t2_bit", 32'(serial_out), 32'(wd[j % 10]));
         chk("t2_valid", 32'(serial_valid), 32'(1));
         chk("t2_cnt", 32'(bit_count), 32'(j % 10));
         chk("t2_ws", 32'(word_start), 32'((j % 10) == 0));
         chk("t2_no_ur", 32'(underrun), 32'(0));
         chk("t2_ready", 32'(in_ready), 32'(((j % 10) == 0) || (j >= 20)));
      end
      tick();
      chk("t2_ur", 32'(underrun), 32'(1));
      chk("t2_idle_valid", 32'(serial_valid), 32'(0));

      // MSB-first instance, word 0x200
      m_data = 10'h200; m_valid = 1'b1;
      @(posedge clk);
      #1;
      m_valid = 1'b0;
      chk("t3_ready_low", 32'(m_ready), 32'(0));
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         chk("t3_bit", 32'(m_sout), 32'(i == 0));
         chk("t3_valid", 32'(m_sval), 32'(1));
         chk("t3_cnt", 32'(m_cnt), 32'(i));
         chk("t3_ws", 32'(m_ws), 32'(i == 0));
      end
      @(posedge clk);
      #1;
      chk("t3_ur", 32'(m_ur), 32'(1));

      // Reset in the middle of a word with a second word held
      prod_q.push_back(10'h3C3);
      parallel_in = 10'h0F0; in_valid = 1'b1;
      repeat (6) tick();
      chk("t4_cnt_before", 32'(bit_count), 32'(4));
      chk("t4_bit_before", 32'(serial_out), 32'(1));
      chk("t4_hold_full", 32'(in_ready), 32'(0));
      rst = 1'b1;
      #1;
      chk("t4_rst_out", 32'(serial_out), 32'(0));
      chk("t4_rst_ready", 32'(in_ready), 32'(0));
      chk("t4_rst_valid", 32'(serial_valid), 32'(0));
      chk("t4_rst_cnt", 32'(bit_count), 32'(0));
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      tick();
      chk("t4_rel_ready", 32'(in_ready), 32'(1));
      for (int i = 0; i < 14; i++) begin
         tick();
         chk("t4_no_bits", 32'(serial_valid), 32'(0));
         chk("t4_no_ur", 32'(underrun), 32'(0));
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
